// File: rtl/hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI access arbiter.
package hpi_pkg;

   localparam int HPI_DATA_W = 16;
   localparam int HPI_ADDR_W = 2;

   localparam int PORT_SW = 0;
   localparam int PORT_HW = 1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      DONE
   } hpi_state_t;

endpackage

// File: rtl/hpi_rr_arbiter2.sv
// Combinational two-way round-robin pick: on contention the port that did not win last time wins.
module hpi_rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       valid
);

   always_comb begin
      valid = |req;
      grant = 1'b0;
      case (req)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/hpi_access_arbiter.sv
// Timed HPI read/write sequencer with a two-port round-robin arbiter.
// Define HPI_TXN_COUNT_EN to add saturating per-port transaction counters.
module hpi_access_arbiter
   import hpi_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES  = 1,
   parameter int unsigned STROBE_CYCLES = 2,
   parameter int unsigned HOLD_CYCLES   = 1,
   parameter int unsigned CNT_W         = 4
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [1:0]            req,
   input  logic [1:0]            we,
   input  logic [HPI_ADDR_W-1:0] addr0,
   input  logic [HPI_ADDR_W-1:0] addr1,
   input  logic [HPI_DATA_W-1:0] wdata0,
   input  logic [HPI_DATA_W-1:0] wdata1,
   output logic [1:0]            ack,
   output logic [HPI_DATA_W-1:0] rdata,
   output logic                  busy,
   output logic [HPI_ADDR_W-1:0] otg_addr,
   output logic [HPI_DATA_W-1:0] otg_data_out,
   output logic                  otg_data_oe,
   input  logic [HPI_DATA_W-1:0] otg_data_in,
   output logic                  otg_cs_n,
   output logic                  otg_rd_n,
   output logic                  otg_wr_n
`ifdef HPI_TXN_COUNT_EN
   ,
   output logic [15:0]           txn_cnt0,
   output logic [15:0]           txn_cnt1
`endif
);

   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

   hpi_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  last_grant_q, last_grant_d;
   logic                  sel_q, sel_d;
   logic                  we_q, we_d;
   logic [HPI_ADDR_W-1:0] addr_q, addr_d;
   logic [HPI_DATA_W-1:0] wdata_q, wdata_d;
   logic [HPI_DATA_W-1:0] rdata_d;
   logic [1:0]            ack_d;
   logic                  active_d;
   logic                  cs_n_d, rd_n_d, wr_n_d, oe_d, busy_d;
   logic                  arb_grant, arb_valid;

   hpi_rr_arbiter2 u_arb (
      .req        (req),
      .last_grant (last_grant_q),
      .grant      (arb_grant),
      .valid      (arb_valid)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      sel_d        = sel_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata;
      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               state_d      = SETUP;
               cnt_d        = SETUP_LD;
               sel_d        = arb_grant;
               last_grant_d = arb_grant;
               we_d         = we[arb_grant];
               if (arb_grant == 1'(PORT_HW)) begin
                  addr_d  = addr1;
                  wdata_d = wdata1;
               end else begin
                  addr_d  = addr0;
                  wdata_d = wdata0;
               end
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               state_d = STROBE;
               cnt_d   = STROBE_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         STROBE: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
               cnt_d   = HOLD_LD;
               // Sample read data on the edge that releases RD_N.
               if (!we_q) rdata_d = otg_data_in;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the pins are registered and aligned with it.
   always_comb begin
      active_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
      cs_n_d   = ~active_d;
      oe_d     = active_d && we_d;
      rd_n_d   = ~((state_d == STROBE) && !we_d);
      wr_n_d   = ~((state_d == STROBE) && we_d);
      busy_d   = (state_d != IDLE);
      ack_d    = '0;
      if (state_d == DONE) ack_d[sel_d] = 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         sel_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata        <= '0;
         ack          <= '0;
         busy         <= 1'b0;
         otg_cs_n     <= 1'b1;
         otg_rd_n     <= 1'b1;
         otg_wr_n     <= 1'b1;
         otg_data_oe  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         sel_q        <= sel_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata        <= rdata_d;
         ack          <= ack_d;
         busy         <= busy_d;
         otg_cs_n     <= cs_n_d;
         otg_rd_n     <= rd_n_d;
         otg_wr_n     <= wr_n_d;
         otg_data_oe  <= oe_d;
      end
   end

   assign otg_addr     = addr_q;
   assign otg_data_out = wdata_q;

`ifdef HPI_TXN_COUNT_EN
   always_ff @(posedge Clk) begin
      if (Reset) begin
         txn_cnt0 <= '0;
         txn_cnt1 <= '0;
      end else begin
         if (ack_d[0] && (txn_cnt0 != 16'hFFFF)) txn_cnt0 <= txn_cnt0 + 16'd1;
         if (ack_d[1] && (txn_cnt1 != 16'hFFFF)) txn_cnt1 <= txn_cnt1 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hpi_access_arbiter.sv
// Scoreboard bench for hpi_access_arbiter: default-timing instance plus a 3/4/2 timing instance.
module tb_hpi_access_arbiter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [1:0]  req, req_b, we;
   logic [1:0]  addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic [15:0] otg_data_in, otg_data_in_b;

   logic [1:0]  ack, ack_b;
   logic [15:0] rdata, rdata_b, otg_data_out, otg_data_out_b;
   logic [1:0]  otg_addr, otg_addr_b;
   logic        busy, busy_b, otg_data_oe, otg_data_oe_b;
   logic        otg_cs_n, otg_rd_n, otg_wr_n, otg_cs_n_b, otg_rd_n_b, otg_wr_n_b;
`ifdef HPI_TXN_COUNT_EN
   logic [15:0] txn_cnt0, txn_cnt1, txn_cnt0_b, txn_cnt1_b;
`endif

   always #5 Clk = ~Clk;

   hpi_access_arbiter u_dut (
      .Clk (Clk), .Reset (Reset), .req (req), .we (we),
      .addr0 (addr0), .addr1 (addr1), .wdata0 (wdata0), .wdata1 (wdata1),
      .ack (ack), .rdata (rdata), .busy (busy), .otg_addr (otg_addr),
      .otg_data_out (otg_data_out), .otg_data_oe (otg_data_oe), .otg_data_in (otg_data_in),
      .otg_cs_n (otg_cs_n), .otg_rd_n (otg_rd_n), .otg_wr_n (otg_wr_n)
`ifdef HPI_TXN_COUNT_EN
      , .txn_cnt0 (txn_cnt0), .txn_cnt1 (txn_cnt1)
`endif
   );

   hpi_access_arbiter #(
      .SETUP_CYCLES (3), .STROBE_CYCLES (4), .HOLD_CYCLES (2), .CNT_W (4)
   ) u_dut_b (
      .Clk (Clk), .Reset (Reset), .req (req_b), .we (we),
      .addr0 (addr0), .addr1 (addr1), .wdata0 (wdata0), .wdata1 (wdata1),
      .ack (ack_b), .rdata (rdata_b), .busy (busy_b), .otg_addr (otg_addr_b),
      .otg_data_out (otg_data_out_b), .otg_data_oe (otg_data_oe_b),
      .otg_data_in (otg_data_in_b),
      .otg_cs_n (otg_cs_n_b), .otg_rd_n (otg_rd_n_b), .otg_wr_n (otg_wr_n_b)
`ifdef HPI_TXN_COUNT_EN
      , .txn_cnt0 (txn_cnt0_b), .txn_cnt1 (txn_cnt1_b)
`endif
   );

   typedef struct {
      logic [1:0]  ack;
      logic        chk_rd;
      logic [15:0] rdata;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic reset_pulse();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
   endtask

   // Ticks until ack rises; n is the cycle number of the ack relative to the first edge.
   task automatic wait_ack(input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (ack === 2'b00 && n < budget);
      if (ack === 2'b00) check("ack_timeout", 32'd0, 32'd1);
   endtask

   always @(negedge Clk) begin
      if (mon_en && !Reset && ack !== 2'b00) begin
         if (q_a.size() == 0) begin
            check("unexpected_ack_a", {30'd0, ack}, 32'd0);
         end else begin
            e_a = q_a.pop_front();
            check("sb_ack_a", {30'd0, ack}, {30'd0, e_a.ack});
            if (e_a.chk_rd) check("sb_rdata_a", {16'd0, rdata}, {16'd0, e_a.rdata});
         end
      end
   end

   always @(negedge Clk) begin
      if (mon_en && !Reset && ack_b !== 2'b00) begin
         if (q_b.size() == 0) begin
            check("unexpected_ack_b", {30'd0, ack_b}, 32'd0);
         end else begin
            e_b = q_b.pop_front();
            check("sb_ack_b", {30'd0, ack_b}, {30'd0, e_b.ack});
            if (e_b.chk_rd) check("sb_rdata_b", {16'd0, rdata_b}, {16'd0, e_b.rdata});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int last;
      int low;
      Reset = 1'b1; req = 2'b00; req_b = 2'b00; we = 2'b00;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      otg_data_in = '0; otg_data_in_b = '0;
      tick();
      tick();
      check("rst_cs_n", {31'd0, otg_cs_n}, 32'd1);
      check("rst_rd_n", {31'd0, otg_rd_n}, 32'd1);
      check("rst_wr_n", {31'd0, otg_wr_n}, 32'd1);
      check("rst_oe", {31'd0, otg_data_oe}, 32'd0);
      check("rst_ack", {30'd0, ack}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rdata", {16'd0, rdata}, 32'd0);
      check("rst_addr", {30'd0, otg_addr}, 32'd0);
      check("rst_dout", {16'd0, otg_data_out}, 32'd0);
      Reset = 1'b0;
      mon_en = 1'b1;

      // Port 0 write, addr 2, data 0x1234.
      req = 2'b01; we = 2'b01; addr0 = 2'd2; wdata0 = 16'h1234;
      q_a.push_back('{ack: 2'b01, chk_rd: 1'b0, rdata: 16'h0});
      for (int i = 1; i <= 5; i++) begin
         tick();
         check("w_cs_n", {31'd0, otg_cs_n}, (i <= 4) ? 32'd0 : 32'd1);
         check("w_wr_n", {31'd0, otg_wr_n}, (i == 2 || i == 3) ? 32'd0 : 32'd1);
         check("w_rd_n", {31'd0, otg_rd_n}, 32'd1);
         check("w_oe", {31'd0, otg_data_oe}, (i <= 4) ? 32'd1 : 32'd0);
         if (i <= 4) begin
            check("w_dout", {16'd0, otg_data_out}, 32'h1234);
            check("w_addr", {30'd0, otg_addr}, 32'd2);
         end
         check("w_ack", {30'd0, ack}, (i == 5) ? 32'd1 : 32'd0);
         check("w_busy", {31'd0, busy}, 32'd1);
         if (i == 5) req = 2'b00;
      end
      tick();
      check("w_idle_busy", {31'd0, busy}, 32'd0);

      // Port 1 read, addr 0, bus returns 0xBEEF.
      req = 2'b10; we = 2'b00; addr1 = 2'd0; otg_data_in = 16'hBEEF;
      q_a.push_back('{ack: 2'b10, chk_rd: 1'b1, rdata: 16'hBEEF});
      for (int i = 1; i <= 5; i++) begin
         tick();
         check("r_rd_n", {31'd0, otg_rd_n}, (i == 2 || i == 3) ? 32'd0 : 32'd1);
         check("r_wr_n", {31'd0, otg_wr_n}, 32'd1);
         check("r_oe", {31'd0, otg_data_oe}, 32'd0);
         check("r_ack", {30'd0, ack}, (i == 5) ? 32'd2 : 32'd0);
         if (i == 5) begin
            check("r_rdata", {16'd0, rdata}, 32'hBEEF);
            req = 2'b00;
         end
      end
      tick();

      // Reset during STROBE of a write: no ack, pins released.
      req = 2'b01; we = 2'b01; addr0 = 2'd1; wdata0 = 16'h55AA;
      tick();
      tick();
      check("mid_wr_n_low", {31'd0, otg_wr_n}, 32'd0);
      Reset = 1'b1;
      tick();
      check("mid_cs_n", {31'd0, otg_cs_n}, 32'd1);
      check("mid_wr_n", {31'd0, otg_wr_n}, 32'd1);
      check("mid_rd_n", {31'd0, otg_rd_n}, 32'd1);
      check("mid_oe", {31'd0, otg_data_oe}, 32'd0);
      check("mid_ack", {30'd0, ack}, 32'd0);
      check("mid_busy", {31'd0, busy}, 32'd0);
      Reset = 1'b0; req = 2'b00;
      repeat (6) tick();
      req = 2'b01; we = 2'b00; otg_data_in = 16'h1357;
      q_a.push_back('{ack: 2'b01, chk_rd: 1'b1, rdata: 16'h1357});
      wait_ack(12, n);
      check("post_rst_latency", n, 32'd5);
      req = 2'b00;
      tick();

      // Both ports held from reset: grants 0,1,0,1 every 6 cycles.
      reset_pulse();
      req = 2'b11; we = 2'b00; otg_data_in = 16'h5A5A;
      for (int k = 0; k < 4; k++)
         q_a.push_back('{ack: (k % 2 == 0) ? 2'b01 : 2'b10, chk_rd: 1'b1, rdata: 16'h5A5A});
      for (int k = 0; k < 4; k++) begin
         wait_ack(12, n);
         check("rr_spacing", n, (k == 0) ? 32'd5 : 32'd6);
         check("rr_order", {30'd0, ack}, (k % 2 == 0) ? 32'd1 : 32'd2);
      end
      req = 2'b00;
      tick();
      tick();

      // Stretched timing instance: 3/4/2 read, ack in cycle 10.
      req_b = 2'b01; we = 2'b00; otg_data_in_b = 16'hC0DE;
      q_b.push_back('{ack: 2'b01, chk_rd: 1'b1, rdata: 16'hC0DE});
      low = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (otg_rd_n_b === 1'b0) low++;
         check("b_rd_n", {31'd0, otg_rd_n_b}, (i >= 4 && i <= 7) ? 32'd0 : 32'd1);
         check("b_cs_n", {31'd0, otg_cs_n_b}, (i <= 9) ? 32'd0 : 32'd1);
         check("b_ack", {30'd0, ack_b}, (i == 10) ? 32'd1 : 32'd0);
         if (i == 10) req_b = 2'b00;
      end
      check("b_rd_low_cycles", low, 32'd4);
      tick();

`ifdef HPI_TXN_COUNT_EN
      reset_pulse();
      we = 2'b11;
      for (int k = 0; k < 5; k++) begin
         req = (k < 3) ? 2'b01 : 2'b10;
         q_a.push_back('{ack: req, chk_rd: 1'b0, rdata: 16'h0});
         wait_ack(12, last);
         req = 2'b00;
         tick();
      end
      check("txn_cnt0", {16'd0, txn_cnt0}, 32'd3);
      check("txn_cnt1", {16'd0, txn_cnt1}, 32'd2);
`endif

      repeat (3) tick();
      check("sb_a_drained", q_a.size(), 32'd0);
      check("sb_b_drained", q_b.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
